uart_rx_cmd: RTL

- 8N1 UART receiver with a single-character command decoder. It is the host-to-board counterpart of the piggy-bank report transmitter.
- It oversamples the serial line, recovers bytes, flags framing errors, and decodes the terminated ASCII commands "S" (send report) and "C" (clear counts).
- Decoded commands become one-cycle pulses. cmd_send drives start_sending on the TX controller. cmd_clear drives the coin-counter clear.

---
 rtl/uart_rx_cmd.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cmd.sv
`default_nettype none
// ============================================================================
// uart_rx_cmd : oversampling 8N1 UART receiver with "S"/"C" + CR/LF command
// decoder; define UART_RX_PARITY_EN for 8E1 framing.        Rev 1.0
// ============================================================================
module uart_rx_cmd #(
  parameter  int CLKS_PER_BIT = 1085,
  localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       cmd_send,
  output logic       cmd_clear
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } state_t;
`endif

  typedef enum logic [1:0] {
    PEND_NONE  = 2'd0,
    PEND_SEND  = 2'd1,
    PEND_CLEAR = 2'd2
  } pend_t;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;
  logic             rx_active_q, rx_active_d;
  logic             frame_err_q, frame_err_d;
  pend_t            pending_q, pending_d;
  logic             cmd_send_q, cmd_send_d;
  logic             cmd_clear_q, cmd_clear_d;
  logic             parity_ok;

`ifdef UART_RX_PARITY_EN
  logic             parity_q, parity_d;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_ok = ~(^{shift_q, parity_q});
`else
  assign parity_ok = 1'b1;
`endif

  assign rx_meta_d = i_Rx_Serial;
  assign rx_s_d    = rx_meta_q;

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_active_d = rx_active_q;
`ifdef UART_RX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          clk_cnt_d   = '0;
          bit_idx_d   = 3'd0;
          rx_active_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt_q == C_HALF_CNT) begin
          clk_cnt_d = '0;
          // A line that is high again at mid-start was only a glitch.
          if (!rx_s_q) begin
            state_d = ST_DATA;
          end else begin
            state_d     = ST_IDLE;
            rx_active_d = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == C_BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == C_BIT_LAST) begin
          clk_cnt_d = '0;
          parity_d  = rx_s_q;
          state_d   = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop lets a start bit that directly follows be caught.
        if (clk_cnt_q == C_BIT_LAST) begin
          clk_cnt_d   = '0;
          state_d     = ST_IDLE;
          rx_active_d = 1'b0;
          if (rx_s_q && parity_ok) begin
            rx_byte_d = shift_q;
            rx_dv_d   = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rx_active_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pending_d   = pending_q;
    cmd_send_d  = 1'b0;
    cmd_clear_d = 1'b0;
    if (frame_err_q) begin
      pending_d = PEND_NONE;
    end else if (rx_dv_q) begin
      case (rx_byte_q)
        8'h53, 8'h73: pending_d = PEND_SEND;
        8'h43, 8'h63: pending_d = PEND_CLEAR;
        8'h0D, 8'h0A: begin
          // With nothing pending the terminator is ignored, so CR LF fires once.
          cmd_send_d  = (pending_q == PEND_SEND);
          cmd_clear_d = (pending_q == PEND_CLEAR);
          pending_d   = PEND_NONE;
        end
        default: pending_d = PEND_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_dv_q     <= 1'b0;
      rx_active_q <= 1'b0;
      frame_err_q <= 1'b0;
      pending_q   <= PEND_NONE;
      cmd_send_q  <= 1'b0;
      cmd_clear_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      rx_active_q <= rx_active_d;
      frame_err_q <= frame_err_d;
      pending_q   <= pending_d;
      cmd_send_q  <= cmd_send_d;
      cmd_clear_q <= cmd_clear_d;
`ifdef UART_RX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign o_Rx_Byte   = rx_byte_q;
  assign o_Rx_DV     = rx_dv_q;
  assign o_Rx_Active = rx_active_q;
  assign o_Frame_Err = frame_err_q;
  assign cmd_send    = cmd_send_q;
  assign cmd_clear   = cmd_clear_q;

endmodule

`default_nettype wire
